// File: rtl/vga_timing_checker.sv
// vga_timing_checker
//
// Passive sink beside the VGA controller. It watches the hSync/vSync pair on
// the pixel strobe, rebuilds the pixel/line counters independently, checks
// line and frame periods, and tracks lock to the raster with a small FSM
// (SEARCH -> ACQUIRE -> LOCKED). It also provides an independent frame-start
// tick for the game logic.
//
// Optional feature macro: VGA_CHK_SYNC_WIDTH_EN
//   When defined, the hSync and vSync pulse widths are checked as well as
//   the periods. When undefined, only the periods are checked.
//
// Ports:
//   clk          system clock (100 MHz)
//   reset        synchronous, active-low reset
//   pix_en       one-cycle pixel strobe; all sampling happens on it
//   hSync        horizontal sync, active low
//   vSync        vertical sync, active low
//   locked       high while the frame timing is verified
//   x, y         recovered column/row; hold their last value outside the
//                visible region
//   active       recovered visible-region flag, only while locked
//   frame_start  one-clk pulse on each vSync fall that leaves us locked
//   h_err        sticky: bad line period (or hSync width)
//   v_err        sticky: bad frame period (or vSync width)
//   err_count    saturating count of pix_en samples that held an error
//
// The timing constants are parameters so that smaller rasters can be used;
// the defaults give 640x480@60.
module vga_timing_checker #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hSync,
  input  logic       vSync,
  output logic       locked,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       active,
  output logic       frame_start,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] CNT_MAX  = 10'h3FF;
`ifdef VGA_CHK_SYNC_WIDTH_EN
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
`endif

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prev_h_q, prev_h_d;
  // vSync as sampled at the previous line start (hSync fall); frame edges
  // are only judged on line boundaries.
  logic        prev_v_q, prev_v_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        locked_q, locked_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        active_q, active_d;
  logic        frame_start_q, frame_start_d;
  logic        h_err_q, h_err_d;
  logic        v_err_q, v_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic h_fall;
  logic v_fall_evt;
  logic line_err;
  logic frame_err;
  logic any_err;
  logic h_in;
  logic v_in;

  always_comb begin
    state_d       = state_q;
    prev_h_d      = prev_h_q;
    prev_v_d      = prev_v_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    locked_d      = locked_q;
    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    frame_start_d = 1'b0;
    h_err_d       = h_err_q;
    v_err_d       = v_err_q;
    err_count_d   = err_count_q;
    h_fall        = 1'b0;
    v_fall_evt    = 1'b0;
    line_err      = 1'b0;
    frame_err     = 1'b0;
    any_err       = 1'b0;
    h_in          = 1'b0;
    v_in          = 1'b0;

    if (pix_en) begin
      h_fall   = prev_h_q & ~hSync;
      prev_h_d = hSync;

      if (h_fall) begin
        hcnt_d   = '0;
        line_err = (hcnt_q != H_LAST);
        prev_v_d = vSync;
        if (prev_v_q & ~vSync) begin
          v_fall_evt = 1'b1;
          vcnt_d     = '0;
          frame_err  = (vcnt_q != V_LAST);
        end else begin
          vcnt_d    = (vcnt_q == CNT_MAX) ? vcnt_q : vcnt_q + 10'd1;
          // Frame timeout: the line count runs past the frame with no fall.
          frame_err = (vcnt_q == V_LAST);
`ifdef VGA_CHK_SYNC_WIDTH_EN
          if (~prev_v_q & vSync & (vcnt_d != V_SYNC_W)) begin
            frame_err = 1'b1;
          end
`endif
        end
      end else begin
        hcnt_d   = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
        // Line timeout: flagged once, on the step onto H_TOTAL.
        line_err = (hcnt_q == H_LAST);
`ifdef VGA_CHK_SYNC_WIDTH_EN
        if (~prev_h_q & hSync & (hcnt_d != H_SYNC_W)) begin
          line_err = 1'b1;
        end
`endif
      end

      any_err = line_err | frame_err;

      case (state_q)
        SEARCH:  state_d = v_fall_evt ? ACQUIRE : SEARCH;
        ACQUIRE: state_d = any_err ? SEARCH : (v_fall_evt ? LOCKED : ACQUIRE);
        LOCKED:  state_d = any_err ? SEARCH : LOCKED;
        default: state_d = SEARCH;
      endcase

      // While searching the raster is not trusted, so errors are ignored.
      if (any_err && (state_q != SEARCH)) begin
        h_err_d     = h_err_q | line_err;
        v_err_d     = v_err_q | frame_err;
        err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
      end

      locked_d      = (state_d == LOCKED);
      // Covers both the ACQUIRE->LOCKED edge and every clean fall in LOCKED.
      frame_start_d = v_fall_evt & (state_d == LOCKED);

      h_in = (hcnt_d >= H_ACT_LO) && (hcnt_d < H_ACT_HI);
      v_in = (vcnt_d >= V_ACT_LO) && (vcnt_d < V_ACT_HI);
      if (h_in) begin
        x_d = hcnt_d - H_ACT_LO;
      end
      if (v_in) begin
        y_d = 9'(vcnt_d - V_ACT_LO);
      end
      active_d = h_in & v_in & locked_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= SEARCH;
      // Sync lines idle high, so a raster that starts low is seen as a fall.
      prev_h_q      <= 1'b1;
      prev_v_q      <= 1'b1;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      locked_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      prev_h_q      <= prev_h_d;
      prev_v_q      <= prev_v_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      locked_q      <= locked_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign locked      = locked_q;
  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_timing_checker.sv
// Bench for vga_timing_checker on a reduced raster (16 x 11) so that many
// frames fit in a short run. A behavioural model of the checker is updated
// on every clock and compared with the DUT half a clock later.
module tb_vga_timing_checker;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VT = VA + VF + VS + VB;
`ifdef VGA_CHK_SYNC_WIDTH_EN
  localparam int W_ERR = 1;
`else
  localparam int W_ERR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pix_en = 1'b0;
  logic       hSync = 1'b1;
  logic       vSync = 1'b1;
  logic       locked;
  logic [9:0] x;
  logic [8:0] y;
  logic       active;
  logic       frame_start;
  logic       h_err;
  logic       v_err;
  logic [7:0] err_count;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int fs_count = 0;
  int glitch_h = 0;
  int glitch_v = 0;

  always #5 clk = ~clk;

  vga_timing_checker #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
    .locked(locked), .x(x), .y(y), .active(active), .frame_start(frame_start),
    .h_err(h_err), .v_err(v_err), .err_count(err_count)
  );

  // ---------------- behavioural model ----------------
  int m_pix;        // pixels since last line start
  int m_line;       // lines since last frame start
  int m_state;      // 0 searching, 1 acquiring, 2 locked
  bit m_last_h;     // hSync at previous strobe
  bit m_line_v;     // vSync at previous line start
  bit m_locked, m_active, m_fs, m_herr, m_verr;
  int m_x, m_y, m_cnt;

  task model_reset();
    m_pix = 0; m_line = 0; m_state = 0; m_last_h = 1'b1; m_line_v = 1'b1;
    m_locked = 0; m_active = 0; m_fs = 0; m_herr = 0; m_verr = 0;
    m_x = 0; m_y = 0; m_cnt = 0;
  endtask

  task model_step(input bit h, input bit v);
    bit new_line, new_frame, bad_line, bad_frame, err;
    int npix, nline, nstate;
    new_line = m_last_h && !h;
    new_frame = 0; bad_line = 0; bad_frame = 0;
    nline = m_line;
    if (new_line) begin
      // the line just finished had m_pix+1 pixels
      bad_line = (m_pix + 1 != HT);
      npix = 0;
      new_frame = m_line_v && !v;
      if (new_frame) begin
        bad_frame = (m_line + 1 != VT);
        nline = 0;
      end else begin
        nline = (m_line >= 1023) ? 1023 : m_line + 1;
        bad_frame = (nline == VT);
      end
`ifdef VGA_CHK_SYNC_WIDTH_EN
      if (!m_line_v && v && nline != VS) bad_frame = 1;
`endif
      m_line_v = v;
    end else begin
      npix = (m_pix >= 1023) ? 1023 : m_pix + 1;
      bad_line = (npix == HT);
    end
`ifdef VGA_CHK_SYNC_WIDTH_EN
    if (!m_last_h && h && npix != HS) bad_line = 1;
`endif
    err = bad_line || bad_frame;
    if (m_state != 0 && err) begin
      m_herr = m_herr | bad_line;
      m_verr = m_verr | bad_frame;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end
    if (m_state == 0) nstate = new_frame ? 1 : 0;
    else if (err) nstate = 0;
    else if (m_state == 1) nstate = new_frame ? 2 : 1;
    else nstate = 2;
    m_state = nstate;
    m_locked = (nstate == 2);
    m_fs = new_frame && m_locked;
    if (npix >= HS + HB && npix < HS + HB + HA) m_x = npix - (HS + HB);
    if (nline >= VS + VB && nline < VS + VB + VA) m_y = nline - (VS + VB);
    m_active = m_locked && (npix >= HS + HB) && (npix < HS + HB + HA) &&
               (nline >= VS + VB) && (nline < VS + VB + VA);
    m_pix = npix;
    m_line = nline;
    m_last_h = h;
  endtask

  task check_cycle();
    logic [31:0] got, want;
    got  = {locked, x, y, active, frame_start, h_err, v_err, err_count};
    want = {m_locked, 10'(m_x), 9'(m_y), m_active, m_fs, m_herr, m_verr, 8'(m_cnt)};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL cycle %0d outputs: got locked=%b x=%0d y=%0d active=%b fs=%b h_err=%b v_err=%b cnt=%0d, want locked=%b x=%0d y=%0d active=%b fs=%b h_err=%b v_err=%b cnt=%0d",
               cycle, locked, x, y, active, frame_start, h_err, v_err, err_count,
               m_locked, m_x, m_y, m_active, m_fs, m_herr, m_verr, m_cnt);
    end
    if (frame_start === 1'b1) fs_count++;
  endtask

  // One clock: model follows the inputs seen at the edge, DUT checked on the
  // falling edge.
  task tick();
    @(posedge clk);
    cycle++;
    if (!reset) model_reset();
    else if (pix_en) model_step(hSync, vSync);
    else m_fs = 0;
    @(negedge clk);
    check_cycle();
  endtask

  task expect_val(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  task pixel(input logic h, input logic v);
    logic hh, vv;
    hh = h;
    vv = v;
    if (glitch_h != 0 && int'($urandom_range(999)) < glitch_h) hh = ~hh;
    if (glitch_v != 0 && int'($urandom_range(999)) < glitch_v) vv = ~vv;
    hSync = hh;
    vSync = vv;
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    repeat (3) tick();
  endtask

  task line_seg(input logic v, input int hc0, input int hc1, input int sw);
    for (int hc = hc0; hc < hc1; hc++) pixel(hc >= sw, v);
  endtask

  task frame(input int nlines, input int short_line, input int narrow_line);
    for (int vc = 0; vc < nlines; vc++)
      line_seg(vc >= VS, 0, (vc == short_line) ? HT - 1 : HT,
               (vc == narrow_line) ? HS - 1 : HS);
  endtask

  task check_all_reset(input string tag);
    expect_val({tag, " locked"}, int'(locked), 0);
    expect_val({tag, " x"}, int'(x), 0);
    expect_val({tag, " y"}, int'(y), 0);
    expect_val({tag, " active"}, int'(active), 0);
    expect_val({tag, " frame_start"}, int'(frame_start), 0);
    expect_val({tag, " h_err"}, int'(h_err), 0);
    expect_val({tag, " v_err"}, int'(v_err), 0);
    expect_val({tag, " err_count"}, int'(err_count), 0);
  endtask

  initial begin
    repeat (3) tick();
    check_all_reset("reset");
    reset = 1'b1;

    // Clean raster: lock at the second vSync fall, pulses at frames 2..4.
    repeat (4) frame(VT, -1, -1);
    $display("[TB] clean raster: locked=%b fs=%0d err=%0d", locked, fs_count, err_count);
    expect_val("clean locked", int'(locked), 1);
    expect_val("clean fs pulses", fs_count, 3);
    expect_val("clean err_count", int'(err_count), 0);
    expect_val("clean last x", int'(x), HA - 1);
    expect_val("clean last y", int'(y), VA - 1);
    expect_val("clean active in porch", int'(active), 0);

    // Stop mid-frame at line 5 pixel 8: visible pixel (2,1).
    for (int vc = 0; vc < 5; vc++) line_seg(vc >= VS, 0, HT, HS);
    line_seg(1'b1, 0, 9, HS);
    expect_val("pin x", int'(x), 2);
    expect_val("pin y", int'(y), 1);
    expect_val("pin active", int'(active), 1);
    line_seg(1'b1, 9, HT, HS);
    for (int vc = 6; vc < VT; vc++) line_seg(vc >= VS, 0, HT, HS);

    // One short line while locked.
    frame(VT, 5, -1);
    $display("[TB] short line: h_err=%b locked=%b err=%0d", h_err, locked, err_count);
    expect_val("short h_err", int'(h_err), 1);
    expect_val("short locked", int'(locked), 0);
    expect_val("short err_count", int'(err_count), 1);
    frame(VT, -1, -1);
    expect_val("short acquiring", int'(locked), 0);
    frame(VT, -1, -1);
    expect_val("short relock", int'(locked), 1);

    // vSync withheld past the frame period.
    for (int i = 0; i < VT + 3; i++) line_seg(1'b1, 0, HT, HS);
    $display("[TB] vsync withheld: v_err=%b locked=%b err=%0d", v_err, locked, err_count);
    expect_val("withheld v_err", int'(v_err), 1);
    expect_val("withheld err_count", int'(err_count), 2);
    expect_val("withheld locked", int'(locked), 0);
    repeat (2) frame(VT, -1, -1);
    expect_val("withheld relock", int'(locked), 1);

    // Short last line and short frame: both errors on one strobe.
    frame(VT - 1, VT - 2, -1);
    frame(VT, -1, -1);
    $display("[TB] coincident errors: err=%0d locked=%b", err_count, locked);
    expect_val("coincident err_count", int'(err_count), 3);
    expect_val("coincident locked", int'(locked), 0);
    repeat (2) frame(VT, -1, -1);
    expect_val("coincident relock", int'(locked), 1);

    // One narrow hSync pulse while locked.
    frame(VT, -1, 3);
    $display("[TB] narrow hsync: err=%0d locked=%b", err_count, locked);
    expect_val("narrow err_count", int'(err_count), 3 + W_ERR);
    expect_val("narrow locked", int'(locked), 1 - W_ERR);
    repeat (2) frame(VT, -1, -1);
    expect_val("narrow relock", int'(locked), 1);

    // Random sync glitches, checked against the model only.
    glitch_h = 5;
    glitch_v = 3;
    repeat (8) frame(VT, -1, -1);
    glitch_h = 0;
    glitch_v = 0;
    $display("[TB] random glitches done: err=%0d", err_count);

    // Reset for one clock mid-frame, between strobes.
    for (int vc = 0; vc < 6; vc++) line_seg(vc >= VS, 0, HT, HS);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    $display("[TB] mid-frame reset applied");
    check_all_reset("midreset");

    // 300 counted errors: each pass enters ACQUIRE and then breaks the line.
    for (int i = 0; i < 300; i++) begin
      pixel(1'b1, 1'b1);
      pixel(1'b0, 1'b1);
      pixel(1'b1, 1'b1);
      pixel(1'b0, 1'b0);
      pixel(1'b1, 1'b0);
      pixel(1'b0, 1'b0);
    end
    $display("[TB] forced errors: err=%0d", err_count);
    expect_val("saturate err_count", int'(err_count), 255);
    expect_val("saturate h_err", int'(h_err), 1);
    expect_val("saturate locked", int'(locked), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
